// File: rtl/mem_wb_pipe_pkg.sv
// Shared definitions for the MEM->WB pipeline stage.
//   RST_ENABLE          : active level of the synchronous reset
//   ZERO_WORD           : all-zero data word
//   REG_BUS_W           : default data / write-back width
//   REG_ADDR_BUS_W      : default register-file address width
//   LDSIZE_*            : load-size codes used by the optional load extender
//   skid_state_e        : occupancy of the two-entry skid buffer
package mem_wb_pipe_pkg;

   localparam logic        RST_ENABLE     = 1'b1;
   localparam int          REG_BUS_W      = 32;
   localparam int          REG_ADDR_BUS_W = 5;
   localparam logic [31:0] ZERO_WORD      = 32'h0000_0000;

   localparam logic [1:0]  LDSIZE_BYTE    = 2'b00;
   localparam logic [1:0]  LDSIZE_HALF    = 2'b01;
   localparam logic [1:0]  LDSIZE_WORD    = 2'b10;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b01,
      ST_FULL  = 2'b10
   } skid_state_e;

endpackage

// File: rtl/mem_wb_ldext.sv
// Combinational load-lane extractor / extender (32-bit words, little-endian lanes).
// Only compiled into the design when MEM_WB_LOAD_EXT_EN is defined.
// Ports:
//   raw     in  32  stored data-memory word
//   addr_lo in  2   low address bits selecting the byte (or half, bit 1) lane
//   ldsize  in  2   00 byte, 01 half, 10/11 word
//   ldsign  in  1   1 = sign-extend, 0 = zero-extend
//   data    out 32  extended load value
`ifdef MEM_WB_LOAD_EXT_EN
module mem_wb_ldext
   import mem_wb_pipe_pkg::*;
(
   input  logic [31:0] raw,
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  ldsize,
   input  logic        ldsign,
   output logic [31:0] data
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   always_comb begin
      lane_b = 8'(raw >> {addr_lo, 3'b000});
      lane_h = 16'(raw >> {addr_lo[1], 4'b0000});
      data   = raw;
      case (ldsize)
         LDSIZE_BYTE: data = {{24{ldsign & lane_b[7]}}, lane_b};
         LDSIZE_HALF: data = {{16{ldsign & lane_h[15]}}, lane_h};
         default:     data = raw;
      endcase
   end

endmodule
`endif

// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline stage with valid/ready on both sides and a two-entry skid
// buffer, so WB backpressure never drops a beat and in_ready comes straight
// from the occupancy register.
// Optional feature macro: MEM_WB_LOAD_EXT_EN (adds mem_ldsize/mem_ldsign and
// byte/half load extraction; requires DATA_W = 32).
// Ports:
//   clk, rst (sync, active-high), flush (sync, drops all held beats)
//   in_valid/in_ready            : MEM-side handshake
//   mem_RegWrite, mem_MemtoReg, memdata, mem_ALUResult, mem_regdst : MEM payload
//   wb_valid/wb_ready            : WB-side handshake
//   wb_RegWrite (r0-guarded), wb_MemtoReg, wb_memdata, wb_ALUResult,
//   wb_regdst, wb_wdata (final register-file write data)
//
// state    | meaning
// ST_EMPTY | no valid entry
// ST_ONE   | main entry valid (drives outputs)
// ST_FULL  | main and skid entries valid, in_ready low
module mem_wb_pipe
   import mem_wb_pipe_pkg::*;
#(
   parameter int DATA_W         = REG_BUS_W,
   parameter int REG_ADDR_W     = REG_ADDR_BUS_W,
   parameter bit ZERO_REG_GUARD = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  mem_RegWrite,
   input  logic                  mem_MemtoReg,
   input  logic [DATA_W-1:0]     memdata,
   input  logic [DATA_W-1:0]     mem_ALUResult,
   input  logic [REG_ADDR_W-1:0] mem_regdst,
`ifdef MEM_WB_LOAD_EXT_EN
   input  logic [1:0]            mem_ldsize,
   input  logic                  mem_ldsign,
`endif
   output logic                  wb_valid,
   input  logic                  wb_ready,
   output logic                  wb_RegWrite,
   output logic                  wb_MemtoReg,
   output logic [DATA_W-1:0]     wb_memdata,
   output logic [DATA_W-1:0]     wb_ALUResult,
   output logic [REG_ADDR_W-1:0] wb_regdst,
   output logic [DATA_W-1:0]     wb_wdata
);

   skid_state_e state, state_nxt;
   logic accept, drain;
   logic load_main_in, load_main_skid, load_skid_in;

   logic                  main_rw, main_m2r, skid_rw, skid_m2r;
   logic [DATA_W-1:0]     main_md, main_alu, skid_md, skid_alu;
   logic [REG_ADDR_W-1:0] main_rd, skid_rd;
`ifdef MEM_WB_LOAD_EXT_EN
   logic [1:0]            main_lsz, skid_lsz;
   logic                  main_lsg, skid_lsg;
`endif

   assign in_ready = (state != ST_FULL) && !rst;
   assign wb_valid = (state != ST_EMPTY);
   assign accept   = in_valid & in_ready;
   assign drain    = wb_valid & wb_ready;

   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) state <= ST_EMPTY;
      else                   state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid_in   = 1'b0;
      case (state)
         ST_EMPTY: if (accept) begin
            state_nxt    = ST_ONE;
            load_main_in = 1'b1;
         end
         ST_ONE: begin
            if (accept && drain) begin
               load_main_in = 1'b1;
            end else if (accept) begin
               state_nxt    = ST_FULL;
               load_skid_in = 1'b1;
            end else if (drain) begin
               state_nxt    = ST_EMPTY;
            end
         end
         ST_FULL: if (drain) begin
            state_nxt      = ST_ONE;
            load_main_skid = 1'b1;
         end
         default: state_nxt = ST_EMPTY;
      endcase
      // A flushed cycle drops everything, including a beat that would have
      // been accepted; a concurrent drain has already been seen by WB.
      if (flush) begin
         state_nxt      = ST_EMPTY;
         load_main_in   = 1'b0;
         load_main_skid = 1'b0;
         load_skid_in   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         main_rw  <= 1'b0;
         main_m2r <= 1'b0;
         main_md  <= DATA_W'(ZERO_WORD);
         main_alu <= DATA_W'(ZERO_WORD);
         main_rd  <= '0;
         skid_rw  <= 1'b0;
         skid_m2r <= 1'b0;
         skid_md  <= DATA_W'(ZERO_WORD);
         skid_alu <= DATA_W'(ZERO_WORD);
         skid_rd  <= '0;
`ifdef MEM_WB_LOAD_EXT_EN
         main_lsz <= '0;
         main_lsg <= 1'b0;
         skid_lsz <= '0;
         skid_lsg <= 1'b0;
`endif
      end else begin
         if (load_main_in) begin
            main_rw  <= mem_RegWrite;
            main_m2r <= mem_MemtoReg;
            main_md  <= memdata;
            main_alu <= mem_ALUResult;
            main_rd  <= mem_regdst;
`ifdef MEM_WB_LOAD_EXT_EN
            main_lsz <= mem_ldsize;
            main_lsg <= mem_ldsign;
`endif
         end else if (load_main_skid) begin
            main_rw  <= skid_rw;
            main_m2r <= skid_m2r;
            main_md  <= skid_md;
            main_alu <= skid_alu;
            main_rd  <= skid_rd;
`ifdef MEM_WB_LOAD_EXT_EN
            main_lsz <= skid_lsz;
            main_lsg <= skid_lsg;
`endif
         end
         if (load_skid_in) begin
            skid_rw  <= mem_RegWrite;
            skid_m2r <= mem_MemtoReg;
            skid_md  <= memdata;
            skid_alu <= mem_ALUResult;
            skid_rd  <= mem_regdst;
`ifdef MEM_WB_LOAD_EXT_EN
            skid_lsz <= mem_ldsize;
            skid_lsg <= mem_ldsign;
`endif
         end
      end
   end

`ifdef MEM_WB_LOAD_EXT_EN
   if (DATA_W != 32) begin : g_width_check
      $error("mem_wb_pipe: MEM_WB_LOAD_EXT_EN requires DATA_W = 32");
   end

   mem_wb_ldext u_ldext (
      .raw     (main_md),
      .addr_lo (main_alu[1:0]),
      .ldsize  (main_lsz),
      .ldsign  (main_lsg),
      .data    (wb_memdata)
   );
`else
   assign wb_memdata = main_md;
`endif

   assign wb_RegWrite  = wb_valid & main_rw & !(ZERO_REG_GUARD && (main_rd == '0));
   assign wb_MemtoReg  = main_m2r;
   assign wb_ALUResult = main_alu;
   assign wb_regdst    = main_rd;
   assign wb_wdata     = main_m2r ? wb_memdata : main_alu;

endmodule
